// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: one-shot / continuous camera frame capture into a
// single-port frame buffer, sharing the port with read requests.
module frame_capture_ctrl #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4,
   parameter int WR_URGENT  = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cap_start,
   input  logic              cap_continuous,
   output logic              cap_busy,
   output logic              cap_done,
   output logic [7:0]        frame_count,
   output logic              overflow,
   input  logic              vsync,
   input  logic              pix_valid,
   input  logic [9:0]        pix_x,
   input  logic [8:0]        pix_y,
   input  logic [15:0]       pix_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic [15:0]       rd_data,
   output logic              rd_data_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_vs_prev;
   logic              r_run;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic [7:0]        r_frame_count;
   logic              r_rd_valid;
   logic [15:0]       r_rd_hold;
   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [15:0]       r_fifo_data [FIFO_DEPTH];

   logic              w_vs_fall;
   logic              w_vs_rise;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_pix_addr;
   logic              w_push_req;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_urgent;
   logic              w_rd_grant;
   logic              w_pop;

   assign w_vs_fall = r_vs_prev & ~vsync;
   assign w_vs_rise = ~r_vs_prev & vsync;

   assign w_in_range = (32'(pix_x) < H_ACTIVE)
                     && (32'(pix_y) < V_ACTIVE);
   assign w_pix_addr = ADDR_W'(pix_y) * ADDR_W'(H_ACTIVE)
                     + ADDR_W'(pix_x);

   assign w_push_req = (r_state == S_CAPTURE) && pix_valid && w_in_range;
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push     = w_push_req && !w_full;

   // r_run holds the memory port quiet until the first edge after reset
   assign w_urgent   = (r_count >= CW'(WR_URGENT));
   assign w_rd_grant = r_run && rd_req && !w_urgent;
   assign w_pop      = r_run && !w_empty && !w_rd_grant;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    if (cap_start) w_state_nxt = S_ARM;
         S_ARM:     if (w_vs_fall) w_state_nxt = S_CAPTURE;
         S_CAPTURE: if (w_vs_rise) w_state_nxt = S_DRAIN;
         S_DRAIN:   if (w_empty && !w_pop) w_state_nxt = S_DONE;
         S_DONE:    w_state_nxt = cap_continuous ? S_ARM : S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_vs_prev     <= 1'b0;
         r_run         <= 1'b0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_frame_count <= '0;
         r_rd_valid    <= 1'b0;
         r_rd_hold     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_vs_prev  <= vsync;
         r_run      <= 1'b1;
         r_rd_valid <= w_rd_grant;
         if (r_rd_valid)
            r_rd_hold <= mem_rdata;
         if (r_state == S_DONE)
            r_frame_count <= r_frame_count + 8'd1;
         if (r_state == S_IDLE && cap_start)
            r_overflow <= 1'b0;
         else if (w_push_req && w_full)
            r_overflow <= 1'b1;
         if (w_push)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_addr[r_wptr] <= w_pix_addr;
         r_fifo_data[r_wptr] <= pix_data;
      end
   end

   assign cap_busy      = (r_state != S_IDLE);
   assign cap_done      = (r_state == S_DONE);
   assign frame_count   = r_frame_count;
   assign overflow      = r_overflow;
   assign rd_grant      = w_rd_grant;
   assign rd_data_valid = r_rd_valid;
   assign rd_data       = r_rd_valid ? mem_rdata : r_rd_hold;
   assign mem_en        = w_rd_grant | w_pop;
   assign mem_we        = w_pop;
   assign mem_addr      = w_pop      ? r_fifo_addr[r_rptr] :
                          w_rd_grant ? rd_addr : '0;
   assign mem_wdata     = w_pop ? r_fifo_data[r_rptr] : '0;

endmodule
